instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Multi-cycle fetch/decode controller that owns the PC and the instruction register (IR) and drives Instr and Imm_Sel into Imm_Gen.
- Sequences FETCH -> DECODE -> EXEC with a req/rdy handshake to instruction memory.
- Hands each decoded instruction to the datapath, then waits for Exec_Done before fetching the next one.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 15, maximum cycles Imem_Req may stay unanswered before a fetch error (range 1..255).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Imem_Req  out  1  fetch request to instruction memory.
- Imem_Addr  out  16  word address; equals PC while Imem_Req=1.
- Imem_Rdy  in  1  memory has valid data on Imem_Data this cycle.
- Imem_Data  in  16  fetched instruction word.
- Instr  out  16  IR contents; drives Imm_Gen.Instr.
- Imm_Sel  out  2  registered immediate-format select; drives Imm_Gen.Imm_Sel.
- Pc_Cur  out  16  address of the instruction held in IR.
- Pc  out  16  next sequential PC.
- Dec_Valid  out  1  one-cycle pulse: Instr/Imm_Sel/Pc_Cur are newly valid.
- Exec_Done  in  1  datapath finished the current instruction.
- Pc_Load  in  1  redirect request; sampled only with Exec_Done.
- Pc_Target  in  16  redirect address.
- Illegal  out  1  one-cycle pulse in DECODE for an undefined opcode.
- Halted  out  1  sticky; high in HALT.
- Fetch_Err  out  1  sticky; high if HALT was entered by timeout.

Behaviour:
- Reset (async, Rst_n=0):
  - PC=RESET_PC; Instr=16'h0000; Imm_Sel=2'b00; Pc_Cur=16'h0000.
  - Dec_Valid, Illegal, Halted, Fetch_Err, Imem_Req all 0; timeout counter=0; state=FETCH.
  - Imem_Req falls immediately on reset assertion, even mid-handshake.
- Opcode = Instr[15:12]:
  - 0000 R-type: Imm_Sel 00.
  - 0001 ADDI: 00.
  - 0010 LW: 00.
  - 0011 SW: 01.
  - 0100 BEQ: 10.
  - 0101 JMP: 11.
  - 1111 HLT: 00.
  - Anything else is illegal: Imm_Sel 00, Illegal pulses, and the instruction is still handed to EXEC as a NOP.
- FETCH:
  - Imem_Req=1, Imem_Addr=PC; counter increments each cycle that Imem_Rdy=0.
  - When Imem_Rdy=1: IR<=Imem_Data, Pc_Cur<=PC, PC<=PC+1 (wraps 16'hFFFF->16'h0000), counter<=0, next state DECODE. Imem_Req drops the following cycle.
  - If counter reaches TIMEOUT with Imem_Rdy still 0: Fetch_Err<=1, next state HALT.
  - A Rdy arriving in the same cycle the count hits TIMEOUT wins: the fetch is accepted.
- DECODE (exactly 1 cycle):
  - Imm_Sel is registered from the IR opcode and is valid at DECODE exit.
  - Dec_Valid=1 for this one cycle.
  - HLT opcode -> HALT; otherwise -> EXEC.
- EXEC:
  - Instr, Imm_Sel and Pc_Cur are held stable.
  - Wait for Exec_Done=1. On that edge, if Pc_Load=1 then PC<=Pc_Target. Next state FETCH.
  - Exec_Done asserted in the same cycle as the DECODE->EXEC transition is not seen until EXEC.
- Signals outside their sampling state are ignored: Imem_Rdy outside FETCH; Exec_Done/Pc_Load outside EXEC.
- HALT:
  - Halted=1; Imem_Req=0; all registers frozen.
  - Only reset exits HALT.
- Latency:
  - Minimum 3 cycles per instruction (Rdy in the first FETCH cycle, Exec_Done in the first EXEC cycle).
  - First Imem_Req is the first cycle after Rst_n deasserts.

Decomposition:
- Package isa_pkg holds:
  - state encoding (FETCH, DECODE, EXEC, HALT);
  - 4-bit opcode constants;
  - Imm_Sel codes 00/01/10/11 (also shared with Imm_Gen).
- One sub-module: opcode_decode, purely combinational. Opcode in; Imm_Sel, is_halt and is_illegal out.

Test Plan:
- Reset, Imem_Rdy held 1, Imem_Data=16'h10EA (ADDI), Exec_Done=1 in first EXEC cycle:
  - Imem_Addr=0000, then Instr=10EA, Imm_Sel=00, Pc_Cur=0000, Pc=0001.
  - Dec_Valid pulses once; the next fetch is at 0001.
- Sequence SW (3xxx), BEQ (4xxx), JMP (5xxx):
  - Imm_Sel reads 01, then 10, then 11, each valid on its Dec_Valid pulse.
- BEQ with Exec_Done=1, Pc_Load=1, Pc_Target=16'h0040:
  - next Imem_Addr=0040, next Pc_Cur=0040.
  - Pc_Load=1 without Exec_Done has no effect.
- Imem_Rdy held 0 for the TIMEOUT cycles (15 at default):
  - Fetch_Err=1, Halted=1, Imem_Req=0.
  - A repeat run with Rdy arriving on cycle 15 completes the fetch normally.
- Fetch F000 (HLT):
  - Dec_Valid pulses, then Halted=1 and no further Imem_Req.
  - Opcode 16'h7000: Illegal pulses and the flow continues to the next fetch.
- Rst_n low mid-FETCH and mid-EXEC, plus PC at FFFF:
  - Imem_Req drops without waiting for a clock edge; PC returns to RESET_PC.
  - Fetch at FFFF leaves Pc=0000.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode controller and Imm_Gen:
// controller state encoding, opcode constants and immediate-format selects.
package isa_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HLT   = 4'hF;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: immediate format, halt and illegal flags.
module opcode_decode
  import isa_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] imm_sel,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    imm_sel    = IMM_I;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_LW: imm_sel = IMM_I;
      OP_SW:                    imm_sel = IMM_S;
      OP_BEQ:                   imm_sel = IMM_B;
      OP_JMP:                   imm_sel = IMM_J;
      OP_HLT:                   is_halt = 1'b1;
      default:                  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Multi-cycle FETCH -> DECODE -> EXEC controller owning PC and IR, with
// req/rdy instruction-memory handshake, fetch timeout and sticky HALT.
module instr_fetch_ctrl
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        Imem_Req,
  output logic [15:0] Imem_Addr,
  input  logic        Imem_Rdy,
  input  logic [15:0] Imem_Data,
  output logic [15:0] Instr,
  output logic [1:0]  Imm_Sel,
  output logic [15:0] Pc_Cur,
  output logic [15:0] Pc,
  output logic        Dec_Valid,
  input  logic        Exec_Done,
  input  logic        Pc_Load,
  input  logic [15:0] Pc_Target,
  output logic        Illegal,
  output logic        Halted,
  output logic        Fetch_Err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  imm_sel_q, imm_sel_d;
  logic [15:0] pc_cur_q, pc_cur_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        fetch_err_q, fetch_err_d;

  logic [3:0]  dec_opcode;
  logic [1:0]  dec_imm_sel;
  logic        dec_is_halt;
  logic        dec_is_illegal;

  // In FETCH the decoder looks at the incoming word so Imm_Sel is loaded
  // together with IR; afterwards it classifies the held IR for DECODE.
  assign dec_opcode = (state_q == ST_FETCH) ? opcode_of(Imem_Data) : opcode_of(ir_q);

  opcode_decode u_opcode_decode (
    .opcode     (dec_opcode),
    .imm_sel    (dec_imm_sel),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imm_sel_d   = imm_sel_q;
    pc_cur_d    = pc_cur_q;
    tmo_cnt_d   = tmo_cnt_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      ST_FETCH: begin
        if (Imem_Rdy) begin
          ir_d      = Imem_Data;
          imm_sel_d = dec_imm_sel;
          pc_cur_d  = pc_q;
          pc_d      = pc_q + 16'd1;
          tmo_cnt_d = '0;
          state_d   = ST_DECODE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_q + 8'd1 == TIMEOUT_CNT) begin
            fetch_err_d = 1'b1;
            state_d     = ST_HALT;
          end
        end
      end
      ST_DECODE: state_d = dec_is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (Exec_Done) begin
          if (Pc_Load) pc_d = Pc_Target;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      imm_sel_q   <= IMM_I;
      pc_cur_q    <= 16'h0000;
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_sel_q   <= imm_sel_d;
      pc_cur_q    <= pc_cur_d;
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Gating with Rst_n drops the request the instant reset asserts.
  assign Imem_Req  = Rst_n && (state_q == ST_FETCH);
  assign Imem_Addr = pc_q;
  assign Instr     = ir_q;
  assign Imm_Sel   = imm_sel_q;
  assign Pc_Cur    = pc_cur_q;
  assign Pc        = pc_q;
  assign Dec_Valid = (state_q == ST_DECODE);
  assign Illegal   = (state_q == ST_DECODE) && dec_is_illegal;
  assign Halted    = (state_q == ST_HALT);
  assign Fetch_Err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized self-checking bench for instr_fetch_ctrl: acts as instruction
// memory and datapath, tracking the expected PC stream per instruction.
module tb_instr_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          TO     = 15;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Imem_Req;
  logic [15:0] Imem_Addr;
  logic        Imem_Rdy = 1'b0;
  logic [15:0] Imem_Data = 16'h0000;
  logic [15:0] Instr;
  logic [1:0]  Imm_Sel;
  logic [15:0] Pc_Cur;
  logic [15:0] Pc;
  logic        Dec_Valid;
  logic        Exec_Done = 1'b0;
  logic        Pc_Load = 1'b0;
  logic [15:0] Pc_Target = 16'h0000;
  logic        Illegal;
  logic        Halted;
  logic        Fetch_Err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_pc = RST_PC;

  instr_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Imem_Req  (Imem_Req),
    .Imem_Addr (Imem_Addr),
    .Imem_Rdy  (Imem_Rdy),
    .Imem_Data (Imem_Data),
    .Instr     (Instr),
    .Imm_Sel   (Imm_Sel),
    .Pc_Cur    (Pc_Cur),
    .Pc        (Pc),
    .Dec_Valid (Dec_Valid),
    .Exec_Done (Exec_Done),
    .Pc_Load   (Pc_Load),
    .Pc_Target (Pc_Target),
    .Illegal   (Illegal),
    .Halted    (Halted),
    .Fetch_Err (Fetch_Err)
  );

  always #5 Clk = ~Clk;

  // Immediate-format table straight from the ISA definition.
  function automatic logic [1:0] ref_imm_sel(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    if (op == 4'h3) return 2'b01;
    if (op == 4'h4) return 2'b10;
    if (op == 4'h5) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic ref_illegal(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    return !((op <= 4'h5) || (op == 4'hF));
  endfunction

  task automatic test_reset(input bit req_before);
    @(negedge Clk);
    #2;
    if (req_before) begin
      n_tests++;
      if (Imem_Req !== 1'b1) begin
        n_fail++; $display("FAIL req_before_reset: got %b want 1", Imem_Req);
      end
    end
    Rst_n = 1'b0;
    #1;
    n_tests++;
    if (Imem_Req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_async: got %b want 0", Imem_Req);
    end
    n_tests++;
    if (Pc !== RST_PC || Instr !== 16'h0000 || Imm_Sel !== 2'b00 || Pc_Cur !== 16'h0000) begin
      n_fail++; $display("FAIL reset_regs: pc=%h instr=%h imm=%b pc_cur=%h want %h 0000 00 0000",
                         Pc, Instr, Imm_Sel, Pc_Cur, RST_PC);
    end
    n_tests++;
    if (Dec_Valid !== 1'b0 || Illegal !== 1'b0 || Halted !== 1'b0 || Fetch_Err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: dv=%b ill=%b halt=%b ferr=%b want 0000",
                         Dec_Valid, Illegal, Halted, Fetch_Err);
    end
    Imem_Rdy = 1'b0; Exec_Done = 1'b0; Pc_Load = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    n_tests++;
    if (Imem_Req !== 1'b1 || Imem_Addr !== RST_PC) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h want 1 %h", Imem_Req, Imem_Addr, RST_PC);
    end
    model_pc = RST_PC;
    $display("[TB] reset applied, pc=%h", Pc);
  endtask

  // One full instruction: optional Rdy wait, DECODE checks, EXEC wait.
  task automatic run_instr(input logic [15:0] word, input int rdy_dly, input int done_dly,
                           input bit load, input logic [15:0] tgt);
    logic [15:0] addr;
    logic [15:0] nxt;
    bit          halt_op;
    addr    = model_pc;
    nxt     = addr + 16'd1;
    halt_op = (word[15:12] == 4'hF);
    n_tests++;
    if (Imem_Req !== 1'b1 || Imem_Addr !== addr) begin
      n_fail++; $display("FAIL fetch_req: req=%b addr=%h want 1 %h", Imem_Req, Imem_Addr, addr);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      Imem_Rdy = 1'b0; Imem_Data = 16'($urandom);
      Exec_Done = 1'($urandom); Pc_Load = 1'($urandom); Pc_Target = 16'($urandom);
      @(negedge Clk);
      n_tests++;
      if (Imem_Req !== 1'b1 || Dec_Valid !== 1'b0 || Halted !== 1'b0 || Imem_Addr !== addr) begin
        n_fail++; $display("FAIL fetch_wait: req=%b dv=%b halt=%b addr=%h want 1 0 0 %h",
                           Imem_Req, Dec_Valid, Halted, Imem_Addr, addr);
      end
    end
    Imem_Rdy = 1'b1; Imem_Data = word;
    @(negedge Clk);
    n_tests++;
    if (Dec_Valid !== 1'b1 || Imem_Req !== 1'b0) begin
      n_fail++; $display("FAIL decode_pulse: dv=%b req=%b want 1 0", Dec_Valid, Imem_Req);
    end
    n_tests++;
    if (Instr !== word || Imm_Sel !== ref_imm_sel(word) || Pc_Cur !== addr || Pc !== nxt) begin
      n_fail++; $display("FAIL decode_regs: instr=%h imm=%b pc_cur=%h pc=%h want %h %b %h %h",
                         Instr, Imm_Sel, Pc_Cur, Pc, word, ref_imm_sel(word), addr, nxt);
    end
    n_tests++;
    if (Illegal !== ref_illegal(word)) begin
      n_fail++; $display("FAIL illegal: got %b want %b for %h", Illegal, ref_illegal(word), word);
    end
    $display("[TB] instr %h @%h imm_sel=%b illegal=%b pc=%h", word, addr, Imm_Sel, Illegal, Pc);
    Imem_Rdy = 1'($urandom); Imem_Data = 16'($urandom);
    Exec_Done = 1'($urandom); Pc_Load = 1'($urandom); Pc_Target = 16'($urandom);
    @(negedge Clk);
    if (halt_op) begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (Halted !== 1'b1 || Imem_Req !== 1'b0 || Fetch_Err !== 1'b0 || Dec_Valid !== 1'b0 || Pc !== nxt) begin
          n_fail++; $display("FAIL halt_hold: halt=%b req=%b ferr=%b dv=%b pc=%h want 1 0 0 0 %h",
                             Halted, Imem_Req, Fetch_Err, Dec_Valid, Pc, nxt);
        end
        Imem_Rdy = 1'b1; Exec_Done = 1'b1; Pc_Load = 1'b1;
        @(negedge Clk);
      end
      Imem_Rdy = 1'b0; Exec_Done = 1'b0; Pc_Load = 1'b0;
      return;
    end
    for (int i = 0; i <= done_dly; i++) begin
      n_tests++;
      if (Dec_Valid !== 1'b0 || Illegal !== 1'b0 || Imem_Req !== 1'b0 || Halted !== 1'b0 ||
          Instr !== word || Imm_Sel !== ref_imm_sel(word) || Pc_Cur !== addr || Pc !== nxt) begin
        n_fail++; $display("FAIL exec_hold: dv=%b ill=%b req=%b halt=%b instr=%h imm=%b pc_cur=%h pc=%h want 0 0 0 0 %h %b %h %h",
                           Dec_Valid, Illegal, Imem_Req, Halted, Instr, Imm_Sel, Pc_Cur, Pc,
                           word, ref_imm_sel(word), addr, nxt);
      end
      Imem_Rdy = 1'($urandom); Imem_Data = 16'($urandom);
      if (i < done_dly) begin
        Exec_Done = 1'b0; Pc_Load = 1'($urandom); Pc_Target = 16'($urandom);
      end else begin
        Exec_Done = 1'b1; Pc_Load = load; Pc_Target = tgt;
      end
      @(negedge Clk);
    end
    Exec_Done = 1'b0; Pc_Load = 1'b0; Imem_Rdy = 1'b0;
    model_pc = load ? tgt : nxt;
  endtask

  task automatic test_basic();
    run_instr(16'h10EA, 0, 0, 1'b0, 16'h0000);
    run_instr(16'h0123, 0, 0, 1'b0, 16'h0000);
  endtask

  task automatic test_imm_formats();
    run_instr(16'h3123, 1, 0, 1'b0, 16'h0000);
    run_instr(16'h4456, 0, 2, 1'b0, 16'h0000);
    run_instr(16'h5789, 2, 1, 1'b0, 16'h0000);
  endtask

  task automatic test_redirect();
    run_instr(16'h4001, 0, 0, 1'b1, 16'h0040);
    run_instr(16'h2000, 0, 3, 1'b0, 16'h0000);
  endtask

  task automatic test_illegal();
    run_instr(16'h7000, 0, 0, 1'b0, 16'h0000);
    run_instr(16'hA5A5, 1, 1, 1'b0, 16'h0000);
    run_instr(16'h1001, 0, 0, 1'b0, 16'h0000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), 16'($urandom));
    end
  endtask

  task automatic test_pc_wrap();
    run_instr(16'h5FFF, 0, 0, 1'b1, 16'hFFFF);
    run_instr(16'h1234, 0, 0, 1'b0, 16'h0000);
    run_instr(16'h0000, 0, 0, 1'b0, 16'h0000);
  endtask

  task automatic test_back_to_back();
    run_instr(16'h2222, TO - 1, 0, 1'b0, 16'h0000);
    run_instr(16'h3333, TO - 1, 0, 1'b0, 16'h0000);
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= TO; i++) begin
      Imem_Rdy = 1'b0; Imem_Data = 16'($urandom);
      @(negedge Clk);
      if (i < TO) begin
        n_tests++;
        if (Halted !== 1'b0 || Fetch_Err !== 1'b0 || Imem_Req !== 1'b1) begin
          n_fail++; $display("FAIL pre_timeout cycle %0d: halt=%b ferr=%b req=%b want 0 0 1",
                             i, Halted, Fetch_Err, Imem_Req);
        end
      end
    end
    n_tests++;
    if (Fetch_Err !== 1'b1 || Halted !== 1'b1 || Imem_Req !== 1'b0) begin
      n_fail++; $display("FAIL timeout: ferr=%b halt=%b req=%b want 1 1 0", Fetch_Err, Halted, Imem_Req);
    end
    for (int i = 0; i < 3; i++) begin
      Imem_Rdy = 1'b1; Imem_Data = 16'h1000;
      @(negedge Clk);
      n_tests++;
      if (Imem_Req !== 1'b0 || Halted !== 1'b1 || Dec_Valid !== 1'b0 || Pc !== model_pc) begin
        n_fail++; $display("FAIL timeout_hold: req=%b halt=%b dv=%b pc=%h want 0 1 0 %h",
                           Imem_Req, Halted, Dec_Valid, Pc, model_pc);
      end
    end
    Imem_Rdy = 1'b0;
    $display("[TB] fetch timeout at pc=%h", Pc);
  endtask

  task automatic test_reset_mid_fetch();
    Imem_Rdy = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset(1'b1);
  endtask

  task automatic test_reset_mid_exec();
    Imem_Rdy = 1'b1; Imem_Data = 16'h2345;
    @(negedge Clk);
    Imem_Rdy = 1'b0; Exec_Done = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (Halted !== 1'b0 || Dec_Valid !== 1'b0 || Instr !== 16'h2345 || Imem_Req !== 1'b0) begin
      n_fail++; $display("FAIL mid_exec_state: halt=%b dv=%b instr=%h req=%b want 0 0 2345 0",
                         Halted, Dec_Valid, Instr, Imem_Req);
    end
    Pc_Load = 1'b1; Pc_Target = 16'hABCD;
    @(negedge Clk);
    n_tests++;
    if (Pc !== model_pc + 16'd1) begin
      n_fail++; $display("FAIL load_without_done: pc=%h want %h", Pc, model_pc + 16'd1);
    end
    Pc_Load = 1'b0;
    test_reset(1'b0);
  endtask

  task automatic test_halt();
    run_instr(16'h1111, 0, 0, 1'b0, 16'h0000);
    run_instr(16'hF000, 0, 0, 1'b0, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset(1'b0);
    test_basic();
    test_imm_formats();
    test_redirect();
    test_illegal();
    test_random();
    test_pc_wrap();
    test_back_to_back();
    test_timeout();
    test_reset(1'b0);
    run_instr(16'h1357, 1, 0, 1'b0, 16'h0000);
    test_reset_mid_fetch();
    run_instr(16'h4444, 0, 0, 1'b0, 16'h0000);
    test_reset_mid_exec();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
